// File: rtl/out_port.sv
// Output-port datapath stage: muxes the allocator-selected input phit, strips the route
// field on granted heads, and tracks packet state, packet count and protocol errors.
module out_port #(
    parameter int unsigned W    = 8,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    in0,
    input  logic [W-1:0]    in1,
    input  logic [W-1:0]    in2,
    input  logic [W-1:0]    in3,
    input  logic [3:0]      select,
    input  logic            shift,
    output logic [W-1:0]    out_phit,
    output logic            out_valid,
    output logic            busy,
    output logic [1:0]      src,
    output logic [CNTW-1:0] pkt_cnt,
    output logic            err
);

    localparam logic [1:0] TYPE_HEAD    = 2'd3;
    localparam logic [1:0] TYPE_PAYLOAD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic            sel_legal;
    logic [1:0]      sel_idx;
    logic [W-1:0]    sel_phit;
    logic [1:0]      sel_type;
    logic            grant;
    logic [W-1:0]    phit_nx;
    logic            valid_nx;
    logic [1:0]      src_nx;
    logic [CNTW-1:0] cnt_nx;
    logic            err_nx;

    // Radial select decode; anything other than a single set bit selects nothing.
    always_comb begin
        sel_legal = 1'b1;
        sel_idx   = 2'd0;
        sel_phit  = '0;
        case (select)
            4'b0001: sel_phit = in0;
            4'b0010: begin sel_idx = 2'd1; sel_phit = in1; end
            4'b0100: begin sel_idx = 2'd2; sel_phit = in2; end
            4'b1000: begin sel_idx = 2'd3; sel_phit = in3; end
            default: sel_legal = 1'b0;
        endcase
        sel_type = sel_phit[W-1:W-2];
    end

    // Next-state, counter, error and output phit.
    always_comb begin
        state_nx = state;
        src_nx   = src;
        cnt_nx   = pkt_cnt;
        err_nx   = err;
        grant    = shift && sel_legal && (sel_type == TYPE_HEAD);
        valid_nx = sel_legal && sel_type[1];
        phit_nx  = shift ? {sel_type, sel_phit[W-5:0], 2'b00} : sel_phit;

        if ((select != 4'd0) && !sel_legal)
            err_nx = 1'b1;
        // A grant must land on a legally selected head.
        if (shift && !grant)
            err_nx = 1'b1;

        if (grant) begin
            state_nx = PKT;
            src_nx   = sel_idx;
            cnt_nx   = pkt_cnt + CNTW'(1);
        end else if (!shift) begin
            case (state)
                IDLE: begin
                    if (select != 4'd0)
                        err_nx = 1'b1;
                end
                PKT: begin
                    if (select == 4'd0) begin
                        state_nx = IDLE;
                    end else if (!((select == (4'b0001 << src)) && (sel_type == TYPE_PAYLOAD))) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_phit  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            src       <= 2'd0;
            pkt_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            out_phit  <= phit_nx;
            out_valid <= valid_nx;
            busy      <= (state_nx == PKT);
            src       <= src_nx;
            pkt_cnt   <= cnt_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_out_port.sv
// Testbench for out_port: directed scenarios plus randomized traffic checked against
// a packet-level reference model.
module tb_out_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in0, in1, in2, in3;
    logic [3:0]  select;
    logic        shift;
    logic [7:0]  out_phit;
    logic        out_valid;
    logic        busy;
    logic [1:0]  src;
    logic [15:0] pkt_cnt;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0]  m_phit;
    logic        m_valid;
    logic        m_busy;
    logic [1:0]  m_src;
    int          m_cnt;
    logic        m_err;

    out_port #(.W(8), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .select(select), .shift(shift),
        .out_phit(out_phit), .out_valid(out_valid), .busy(busy),
        .src(src), .pkt_cnt(pkt_cnt), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic model_step(input logic r, input logic [7:0] a, b, c, d,
                              input logic [3:0] s, input logic sh);
        logic [7:0] ins [4];
        bit   legal;
        int   idx;
        int   phit;
        int   typ;
        bit   hold_ok;
        ins[0] = a; ins[1] = b; ins[2] = c; ins[3] = d;
        if (r) begin
            m_phit = 0; m_valid = 0; m_busy = 0; m_src = 0; m_cnt = 0; m_err = 0;
            return;
        end
        legal = ($countones(s) == 1);
        idx   = legal ? $clog2(s) : 0;
        phit  = legal ? int'(ins[idx]) : 0;
        typ   = phit / 64;
        m_valid = legal && (typ >= 2);
        if (!legal)  m_phit = 0;
        else if (sh) m_phit = 8'(typ * 64 + (phit % 16) * 4);
        else         m_phit = 8'(phit);
        if (s != 0 && !legal) m_err = 1;
        if (sh && legal && typ == 3) begin
            m_busy = 1;
            m_src  = 2'(idx);
            m_cnt  = (m_cnt + 1) % 65536;
        end else if (sh) begin
            m_err = 1;
        end else if (!m_busy) begin
            if (s != 0) m_err = 1;
        end else if (s != 0) begin
            hold_ok = legal && (idx == int'(m_src)) && (typ == 2);
            if (!hold_ok) begin
                m_err  = 1;
                m_busy = 0;
            end
        end else begin
            m_busy = 0;
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] a, b, c, d,
                         input logic [3:0] s, input logic sh);
        @(negedge clk);
        rst = r; in0 = a; in1 = b; in2 = c; in3 = d; select = s; shift = sh;
        model_step(r, a, b, c, d, s, sh);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++)
            drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  4'($urandom), 1'($urandom));
        n_cmp++;
        if ({out_phit, out_valid, busy, src, pkt_cnt, err} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset: phit=%h valid=%b busy=%b src=%0d cnt=%h err=%b, want all 0",
                     out_phit, out_valid, busy, src, pkt_cnt, err);
        end
    endtask

    task automatic test_head_grant;
        drive(1'b0, 8'h00, 8'h00, 8'hE7, 8'h00, 4'b0100, 1'b1);
        n_cmp++;
        if (out_phit !== 8'hDC || out_valid !== 1'b1 || busy !== 1'b1 ||
            src !== 2'd2 || pkt_cnt !== 16'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL head_grant: phit=%h valid=%b busy=%b src=%0d cnt=%0d err=%b, want DC 1 1 2 1 0",
                     out_phit, out_valid, busy, src, pkt_cnt, err);
        end
    endtask

    task automatic test_payload;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 4'b0100, 1'b0);
            n_cmp++;
            if (out_phit !== 8'hA5 || out_valid !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL payload[%0d]: phit=%h valid=%b busy=%b err=%b, want A5 1 1 0",
                         i, out_phit, out_valid, busy, err);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 4'b0000, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_phit !== 8'h00 ||
            pkt_cnt !== 16'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL payload_end: phit=%h valid=%b busy=%b cnt=%0d err=%b, want 00 0 0 1 0",
                     out_phit, out_valid, busy, pkt_cnt, err);
        end
    endtask

    task automatic test_bad_select;
        drive(1'b0, 8'hC3, 8'hA1, 8'h00, 8'h00, 4'b0011, 1'b0);
        n_cmp++;
        if (out_phit !== 8'h00 || out_valid !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_select: phit=%h valid=%b err=%b, want 00 0 1",
                     out_phit, out_valid, err);
        end
        for (int i = 0; i < 3; i++)
            drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        n_cmp++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
    endtask

    task automatic test_cnt_wrap;
        drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        for (int i = 0; i < 65535; i++)
            drive(1'b0, 8'hC0, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b1);
        n_cmp++;
        if (pkt_cnt !== 16'hFFFF || err !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_full: cnt=%h err=%b, want FFFF 0", pkt_cnt, err);
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'hC8, 4'b1000, 1'b1);
        n_cmp++;
        if (pkt_cnt !== 16'h0000 || busy !== 1'b1 || src !== 2'd3 || out_phit !== 8'hE0) begin
            n_fail++;
            $display("FAIL cnt_wrap: cnt=%h busy=%b src=%0d phit=%h, want 0000 1 3 E0",
                     pkt_cnt, busy, src, out_phit);
        end
    endtask

    task automatic test_reset_mid_packet;
        drive(1'b0, 8'h00, 8'hD4, 8'h00, 8'h00, 4'b0010, 1'b1);
        drive(1'b0, 8'h00, 8'h99, 8'h00, 8'h00, 4'b0010, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || src !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_pkt_setup: busy=%b src=%0d, want 1 1", busy, src);
        end
        drive(1'b1, 8'h00, 8'h99, 8'h00, 8'h00, 4'b0010, 1'b0);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || pkt_cnt !== 16'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pkt_reset: busy=%b valid=%b cnt=%0d err=%b, want 0 0 0 0",
                     busy, out_valid, pkt_cnt, err);
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'hF6, 4'b1000, 1'b1);
        n_cmp++;
        if (busy !== 1'b1 || src !== 2'd3 || pkt_cnt !== 16'd1 || out_valid !== 1'b1 ||
            out_phit !== 8'hD8 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_head: busy=%b src=%0d cnt=%0d valid=%b phit=%h err=%b, want 1 3 1 1 D8 0",
                     busy, src, pkt_cnt, out_valid, out_phit, err);
        end
    endtask

    function automatic logic [3:0] rand_select(input int kind);
        if (kind < 75) return 4'b0001 << $urandom_range(0, 3);
        if (kind < 90) return 4'b0000;
        return 4'($urandom);
    endfunction

    task automatic test_random;
        logic [7:0] v [4];
        logic [3:0] s;
        logic       sh;
        logic       r;
        drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) v[k] = 8'($urandom);
            s  = rand_select(int'($urandom_range(0, 99)));
            sh = ($urandom_range(0, 99) < 25);
            r  = ($urandom_range(0, 99) < 3);
            drive(r, v[0], v[1], v[2], v[3], s, sh);
            n_cmp++;
            if (out_phit !== m_phit || out_valid !== m_valid || busy !== m_busy ||
                src !== m_src || pkt_cnt !== 16'(m_cnt) || err !== m_err) begin
                n_fail++;
                $display("FAIL random[%0d]: got phit=%h v=%b busy=%b src=%0d cnt=%0d err=%b, want phit=%h v=%b busy=%b src=%0d cnt=%0d err=%b",
                         i, out_phit, out_valid, busy, src, pkt_cnt, err,
                         m_phit, m_valid, m_busy, m_src, m_cnt, m_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in0 = '0; in1 = '0; in2 = '0; in3 = '0; select = '0; shift = 1'b0;
        test_reset;
        test_head_grant;
        test_payload;
        test_bad_select;
        test_cnt_wrap;
        test_reset_mid_packet;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
